// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master dmem arbiter with parked grant, bounded hold and address/alignment checks
module dmem_arbiter #(
  parameter int          ADDR_W   = 11,
  parameter logic [31:0] BASE     = 32'h1001_0000,
  parameter int          MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_rd,
  input  logic [1:0]        m0_size,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_rd,
  input  logic [1:0]        m1_size,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [31:0]       m1_rdata,
  output logic              dm_cs,
  output logic              dm_r,
  output logic              dm_w_w,
  output logic              dm_w_h,
  output logic              dm_w_b,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_data_in,
  input  logic [31:0]       dm_data_out
);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(MAX_HOLD - 1);
  logic              owner_q, owner_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              s_req, s_rd, s_err, x_req, go, acc, keep;
  logic [1:0]        s_size;
  logic [31:0]       s_addr, s_wdata, off;
  always_comb begin
    s_req   = owner_q ? m1_req : m0_req;
    s_rd    = owner_q ? m1_rd : m0_rd;
    s_size  = owner_q ? m1_size : m0_size;
    s_addr  = owner_q ? m1_addr : m0_addr;
    s_wdata = owner_q ? m1_wdata : m0_wdata;
    x_req   = owner_q ? m0_req : m1_req;
    off     = s_addr - BASE;
    s_err   = ((off >> ADDR_W) != 32'd0) || (s_size == 2'b00) ||
              (s_size == 2'b11 && s_addr[1:0] != 2'b00) || (s_size == 2'b10 && s_addr[0]);
    go      = rst && s_req;
    acc     = go && !s_err;
    m0_ack  = go && !owner_q;
    m1_ack  = go && owner_q;
    m0_err  = m0_ack && s_err;
    m1_err  = m1_ack && s_err;
    m0_rdata = (m0_ack && acc && s_rd) ? dm_data_out : 32'd0;
    m1_rdata = (m1_ack && acc && s_rd) ? dm_data_out : 32'd0;
    dm_cs   = acc;
    dm_r    = acc && s_rd;
    dm_w_w  = acc && !s_rd && s_size == 2'b11;
    dm_w_h  = acc && !s_rd && s_size == 2'b10;
    dm_w_b  = acc && !s_rd && s_size == 2'b01;
    dm_addr = acc ? off[ADDR_W-1:0] : '0;
    dm_data_in = (acc && !s_rd) ? s_wdata : 32'd0;
    // owner keeps the grant while it keeps transferring, up to MAX_HOLD in a row against a waiter
    keep    = s_req && hold_q < LAST;
    owner_d = (x_req && !keep) ? !owner_q : owner_q;
    hold_d  = (x_req && keep) ? hold_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a per-cycle behavioural model of grants, errors and memory
module tb_dmem_arbiter;
  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int MAX_HOLD = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic m0_req = 1'b0, m0_rd = 1'b0, m1_req = 1'b0, m1_rd = 1'b0;
  logic [1:0] m0_size = 2'd0, m1_size = 2'd0;
  logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0, m1_addr = 32'd0, m1_wdata = 32'd0;
  logic m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata, dm_data_in, dm_data_out;
  logic dm_cs, dm_r, dm_w_w, dm_w_h, dm_w_b;
  logic [10:0] dm_addr;
  logic [7:0] mem [0:2047];
  logic [7:0] ref_mem [0:2047];
  int checks = 0, errors = 0;
  int own = 0, streak = 0;
  logic s_err;
  logic [31:0] s_rdata;
  logic [10:0] s_addr;
  logic [4:0] s_strb;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(11), .BASE(BASE), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_rd(m0_rd), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_rd(m1_rd), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dm_cs(dm_cs), .dm_r(dm_r), .dm_w_w(dm_w_w), .dm_w_h(dm_w_h), .dm_w_b(dm_w_b),
    .dm_addr(dm_addr), .dm_data_in(dm_data_in), .dm_data_out(dm_data_out)
  );

  assign dm_data_out = {mem[{dm_addr[10:2], 2'd3}], mem[{dm_addr[10:2], 2'd2}],
                        mem[{dm_addr[10:2], 2'd1}], mem[{dm_addr[10:2], 2'd0}]};

  always @(posedge clk) begin
    if (dm_cs && !dm_r && dm_w_w) begin
      mem[dm_addr] <= dm_data_in[7:0];
      mem[dm_addr + 11'd1] <= dm_data_in[15:8];
      mem[dm_addr + 11'd2] <= dm_data_in[23:16];
      mem[dm_addr + 11'd3] <= dm_data_in[31:24];
    end
    if (dm_cs && !dm_r && dm_w_h) begin
      mem[dm_addr] <= dm_data_in[7:0];
      mem[dm_addr + 11'd1] <= dm_data_in[15:8];
    end
    if (dm_cs && !dm_r && dm_w_b) mem[dm_addr] <= dm_data_in[7:0];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic bad(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] o;
    o = a - BASE;
    return (o > 32'd2047) || (sz == 2'd0) || (sz == 2'd3 && a[1:0] != 2'd0) || (sz == 2'd2 && a[0]);
  endfunction

  function automatic logic [31:0] ref_word(input int o);
    int b;
    b = o & ~3;
    return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
  endfunction

  initial forever begin
    logic preq, oreq, prd, b, acc;
    logic [1:0] psz;
    logic [31:0] pa, pw, erd;
    int o;
    @(negedge clk);
    if (!rst) begin
      own = 0;
      streak = 0;
      chk("rst_ack_err", {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
      chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
      chk("rst_strobes", {27'd0, dm_cs, dm_r, dm_w_w, dm_w_h, dm_w_b}, 32'd0);
      chk("rst_addr_data", dm_data_in | {21'd0, dm_addr}, 32'd0);
    end else begin
      preq = own == 1 ? m1_req : m0_req;
      oreq = own == 1 ? m0_req : m1_req;
      prd  = own == 1 ? m1_rd : m0_rd;
      psz  = own == 1 ? m1_size : m0_size;
      pa   = own == 1 ? m1_addr : m0_addr;
      pw   = own == 1 ? m1_wdata : m0_wdata;
      b    = bad(pa, psz);
      o    = int'(pa - BASE) & 2047;
      acc  = preq && !b;
      erd  = (acc && prd) ? ref_word(o) : 32'd0;
      chk("ack0", {31'd0, m0_ack}, {31'd0, own == 0 && preq});
      chk("ack1", {31'd0, m1_ack}, {31'd0, own == 1 && preq});
      chk("err0", {31'd0, m0_err}, {31'd0, own == 0 && preq && b});
      chk("err1", {31'd0, m1_err}, {31'd0, own == 1 && preq && b});
      chk("rdata0", m0_rdata, own == 0 ? erd : 32'd0);
      chk("rdata1", m1_rdata, own == 1 ? erd : 32'd0);
      chk("strobes", {27'd0, dm_cs, dm_r, dm_w_w, dm_w_h, dm_w_b},
          {27'd0, acc, acc && prd, acc && !prd && psz == 2'd3, acc && !prd && psz == 2'd2, acc && !prd && psz == 2'd1});
      if (acc) chk("dm_addr", {21'd0, dm_addr}, o);
      if (acc && !prd) chk("dm_data_in", dm_data_in, pw);
      if (acc && !prd) begin
        ref_mem[o] = pw[7:0];
        if (psz != 2'd1) ref_mem[o + 1] = pw[15:8];
        if (psz == 2'd3) begin
          ref_mem[o + 2] = pw[23:16];
          ref_mem[o + 3] = pw[31:24];
        end
      end
      if (!oreq) streak = 0;
      else if (preq && streak + 1 < MAX_HOLD) streak++;
      else begin
        own = 1 - own;
        streak = 0;
      end
    end
  end

  task automatic issue(input int p, input logic rd, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    if (p == 1) begin
      m1_rd = rd; m1_size = sz; m1_addr = a; m1_wdata = wd; m1_req = 1'b1;
    end else begin
      m0_rd = rd; m0_size = sz; m0_addr = a; m0_wdata = wd; m0_req = 1'b1;
    end
  endtask

  task automatic drop(input int p);
    if (p == 1) m1_req = 1'b0;
    else m0_req = 1'b0;
  endtask

  task automatic wait_ack(input int p, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (p == 1 ? m1_ack : m0_ack) begin
        s_err = p == 1 ? m1_err : m0_err;
        s_rdata = p == 1 ? m1_rdata : m0_rdata;
        s_addr = dm_addr;
        s_strb = {dm_cs, dm_r, dm_w_w, dm_w_h, dm_w_b};
        break;
      end
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $display("FAIL ack_timeout port=%0d actual=no_ack required=ack", p);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [8:0] pat;
    logic [31:0] ea [5];
    logic [1:0] es [5];
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 8'd0;
      ref_mem[i] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    issue(0, 1'b0, 2'd3, 32'h1001_0004, 32'hDEAD_BEEF);
    wait_ack(0, n);
    chk("t1_wr_latency", n, 0);
    chk("t1_wr_strobes", {27'd0, s_strb}, 32'b10100);
    issue(0, 1'b1, 2'd3, 32'h1001_0004, 32'd0);
    wait_ack(0, n);
    chk("t1_rd_latency", n, 0);
    chk("t1_rd_data", s_rdata, 32'hDEAD_BEEF);
    chk("t1_rd_strobes", {27'd0, s_strb}, 32'b11000);
    drop(0);
    @(posedge clk);
    #1;
    issue(0, 1'b1, 2'd3, 32'h1001_0004, 32'd0);
    issue(1, 1'b1, 2'd3, 32'h1001_0004, 32'd0);
    pat = 9'b1_0000_1111;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("t2_ack0_%0d", i), {31'd0, m0_ack}, {31'd0, pat[i]});
      chk($sformatf("t2_ack1_%0d", i), {31'd0, m1_ack}, {31'd0, !pat[i]});
      @(posedge clk);
      #1;
    end
    drop(0);
    drop(1);
    @(posedge clk);
    #1;
    issue(1, 1'b0, 2'd3, 32'h1001_0010, 32'h1234_5678);
    wait_ack(1, n);
    chk("t3_m1_latency", n, 1);
    drop(1);
    issue(0, 1'b1, 2'd3, 32'h1001_0010, 32'd0);
    wait_ack(0, n);
    chk("t3_m0_latency", n, 1);
    chk("t3_m0_rdata", s_rdata, 32'h1234_5678);
    ea = '{32'h1001_0002, 32'h1001_0001, 32'h1001_0800, 32'h0FFF_FFFC, 32'h1001_0004};
    es = '{2'd3, 2'd2, 2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      issue(0, 1'b0, es[i], ea[i], 32'hFFFF_FFFF);
      wait_ack(0, n);
      chk($sformatf("t4_latency_%0d", i), n, 0);
      chk($sformatf("t4_err_%0d", i), {31'd0, s_err}, 32'd1);
      chk($sformatf("t4_strobes_%0d", i), {27'd0, s_strb}, 32'd0);
    end
    issue(0, 1'b1, 2'd3, 32'h1001_0004, 32'd0);
    wait_ack(0, n);
    chk("t4_word4_kept", s_rdata, 32'hDEAD_BEEF);
    issue(0, 1'b1, 2'd3, 32'h1001_0000, 32'd0);
    wait_ack(0, n);
    chk("t4_word0_kept", s_rdata, 32'd0);
    drop(0);
    issue(1, 1'b0, 2'd1, 32'h1001_0003, 32'h1234_56AB);
    wait_ack(1, n);
    chk("t5_byte_latency", n, 1);
    chk("t5_byte_strobes", {27'd0, s_strb}, 32'b10001);
    chk("t5_byte_addr", {21'd0, s_addr}, 32'd3);
    issue(1, 1'b0, 2'd2, 32'h1001_07FE, 32'h0000_5A5A);
    wait_ack(1, n);
    chk("t5_half_err", {31'd0, s_err}, 32'd0);
    chk("t5_half_strobes", {27'd0, s_strb}, 32'b10010);
    chk("t5_half_addr", {21'd0, s_addr}, 32'h7FE);
    issue(1, 1'b1, 2'd3, 32'h1001_0000, 32'd0);
    wait_ack(1, n);
    chk("t5_byte_read", s_rdata, 32'hAB00_0000);
    issue(1, 1'b1, 2'd3, 32'h1001_07FC, 32'd0);
    wait_ack(1, n);
    chk("t5_half_read", s_rdata, 32'h5A5A_0000);
    drop(1);
    @(posedge clk);
    #1;
    issue(1, 1'b0, 2'd3, 32'h1001_0020, 32'hCAFE_F00D);
    #1;
    chk("t6_pre_strobes", {27'd0, dm_cs, dm_r, dm_w_w, dm_w_h, dm_w_b}, 32'b10100);
    rst = 1'b0;
    #1;
    chk("t6_rst_strobes", {27'd0, dm_cs, dm_r, dm_w_w, dm_w_h, dm_w_b}, 32'd0);
    chk("t6_rst_ack", {31'd0, m1_ack}, 32'd0);
    drop(1);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_mem_unchanged", {mem[35], mem[34], mem[33], mem[32]}, 32'd0);
    rst = 1'b1;
    issue(1, 1'b0, 2'd3, 32'h1001_0020, 32'hCAFE_F00D);
    wait_ack(1, n);
    chk("t6_reissue_latency", n, 1);
    issue(1, 1'b1, 2'd3, 32'h1001_0020, 32'd0);
    wait_ack(1, n);
    chk("t6_reissue_read", s_rdata, 32'hCAFE_F00D);
    drop(1);
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
